// File: rtl/alu_iter.sv
// Execute-stage ALU: single-cycle base integer ops plus iterative multiply/divide.
// Holds one op at a time behind valid/ready handshakes on both sides.
module alu_iter #(
  parameter int XLEN     = 32,
  parameter int MUL_STEP = 1,
  localparam int SHW     = $clog2(XLEN)
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            kill,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [4:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            zero,
  output logic            less_than,
  output logic            less_than_unsigned
);

  localparam logic [SHW:0] MUL_CYC = (SHW+1)'(XLEN / MUL_STEP);
  localparam logic [SHW:0] DIV_CYC = (SHW+1)'(XLEN);
  localparam logic [SHW:0] ONE     = (SHW+1)'(1);

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;

  state_t          state;
  logic [XLEN-1:0] hi, lo, opnd;
  logic            neg, sel;
  logic [SHW:0]    cnt;
  logic            accept;

  assign in_ready = ~kill & ((state == IDLE) | ((state == DONE) & out_ready));
  assign accept   = in_valid & in_ready;

  // One subtract feeds sub, the compare flags and slt/sltu
  logic [XLEN:0]   diff;
  logic            f_zero, f_lt, f_ltu;
  logic [SHW-1:0]  shamt;
  logic [XLEN-1:0] base_res;

  assign diff   = {1'b1, ~src2} + {1'b0, src1} + {{XLEN{1'b0}}, 1'b1};
  assign f_ltu  = diff[XLEN];
  assign f_lt   = (src1[XLEN-1] ^ src2[XLEN-1]) ? src1[XLEN-1] : diff[XLEN];
  assign f_zero = (diff[XLEN-1:0] == '0);
  assign shamt  = src2[SHW-1:0];

  always_comb begin
    base_res = '0;
    case (op[3:0])
      4'b0000: base_res = src1 + src2;
      4'b1000: base_res = diff[XLEN-1:0];
      4'b0110: base_res = src1 | src2;
      4'b0111: base_res = src1 & src2;
      4'b0100: base_res = src1 ^ src2;
      4'b0010: base_res = XLEN'(f_lt);
      4'b0011: base_res = XLEN'(f_ltu);
      4'b0001: base_res = src1 << shamt;
      4'b0101: base_res = src1 >> shamt;
      4'b1101: base_res = $signed(src1) >>> shamt;
      default: base_res = '0;
    endcase
  end

  // M-extension operand conditioning
  logic [2:0]      f3;
  logic            is_div, sgn_a, sgn_b, a_neg, b_neg, div0, ovf;
  logic [XLEN-1:0] mag_a, mag_b, fast_res;

  assign f3       = op[2:0];
  assign is_div   = f3[2];
  assign sgn_a    = is_div ? ~f3[0] : (f3[1] ^ f3[0]);
  assign sgn_b    = is_div ? ~f3[0] : (f3[1:0] == 2'b01);
  assign a_neg    = sgn_a & src1[XLEN-1];
  assign b_neg    = sgn_b & src2[XLEN-1];
  assign mag_a    = a_neg ? -src1 : src1;
  assign mag_b    = b_neg ? -src2 : src2;
  assign div0     = (src2 == '0);
  assign ovf      = ~f3[0] & (src1 == {1'b1, {(XLEN-1){1'b0}}}) & (&src2);
  assign fast_res = div0 ? (f3[1] ? src1 : '1) : (f3[1] ? '0 : src1);

  // Multiply step: {hi,lo} shifts right MUL_STEP bits, lo starts as multiplier
  logic [XLEN+MUL_STEP-1:0] msum;
  logic [XLEN-1:0]          m_hi, m_lo, mul_res;
  logic [2*XLEN-1:0]        prod, prod_fix;

  always_comb begin
    msum = {{MUL_STEP{1'b0}}, hi};
    for (int i = 0; i < MUL_STEP; i++)
      if (lo[i]) msum = msum + ({{MUL_STEP{1'b0}}, opnd} << i);
  end

  assign m_hi     = msum[XLEN+MUL_STEP-1:MUL_STEP];
  assign m_lo     = {msum[MUL_STEP-1:0], lo[XLEN-1:MUL_STEP]};
  assign prod     = {m_hi, m_lo};
  assign prod_fix = neg ? -prod : prod;
  assign mul_res  = sel ? prod_fix[2*XLEN-1:XLEN] : prod_fix[XLEN-1:0];

  // Restoring divide: hi is the partial remainder, lo shifts dividend out and quotient in
  logic [XLEN:0]   dtry;
  logic            dok;
  logic [XLEN-1:0] d_hi, d_lo, d_pick, div_res;

  assign dtry    = {hi, lo[XLEN-1]} - {1'b0, opnd};
  assign dok     = ~dtry[XLEN];
  assign d_hi    = dok ? dtry[XLEN-1:0] : {hi[XLEN-2:0], lo[XLEN-1]};
  assign d_lo    = {lo[XLEN-2:0], dok};
  assign d_pick  = sel ? d_hi : d_lo;
  assign div_res = neg ? -d_pick : d_pick;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state              <= IDLE;
      out_valid          <= 1'b0;
      result             <= '0;
      zero               <= 1'b0;
      less_than          <= 1'b0;
      less_than_unsigned <= 1'b0;
      hi                 <= '0;
      lo                 <= '0;
      opnd               <= '0;
      neg                <= 1'b0;
      sel                <= 1'b0;
      cnt                <= '0;
    end else if (kill) begin
      state     <= IDLE;
      out_valid <= 1'b0;
      cnt       <= '0;
    end else begin
      case (state)
        MUL: begin
          hi  <= m_hi;
          lo  <= m_lo;
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            result    <= mul_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DIV: begin
          hi  <= d_hi;
          lo  <= d_lo;
          cnt <= cnt - ONE;
          if (cnt == ONE) begin
            result    <= div_res;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: if (out_ready) begin
          out_valid <= 1'b0;
          state     <= IDLE;
        end
        default: ;
      endcase

      if (accept) begin
        zero               <= f_zero;
        less_than          <= f_lt;
        less_than_unsigned <= f_ltu;
        cnt                <= '0;
        if (!op[4]) begin
          result    <= base_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end else if (!is_div) begin
          hi        <= '0;
          lo        <= mag_b;
          opnd      <= mag_a;
          neg       <= a_neg ^ b_neg;
          sel       <= (f3[1:0] != 2'b00);
          cnt       <= MUL_CYC;
          out_valid <= 1'b0;
          state     <= MUL;
        end else if (div0 | ovf) begin
          result    <= fast_res;
          out_valid <= 1'b1;
          state     <= DONE;
        end else begin
          hi        <= '0;
          lo        <= mag_a;
          opnd      <= mag_b;
          neg       <= f3[1] ? a_neg : (a_neg ^ b_neg);
          sel       <= f3[1];
          cnt       <= DIV_CYC;
          out_valid <= 1'b0;
          state     <= DIV;
        end
      end
    end
  end

endmodule

// File: tb/tb_alu_iter.sv
// Scoreboard bench for alu_iter: XLEN=32/MUL_STEP=1 instance plus an XLEN=64/MUL_STEP=4 instance.
module tb_alu_iter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, kill, in_valid, out_ready;
  logic [4:0]  op;
  logic [31:0] src1, src2, result;
  logic        in_ready, out_valid, zero, less_than, less_than_unsigned;

  logic        in_valid64, in_ready64, out_valid64, zero64, lt64, ltu64;
  logic [63:0] src1_64, src2_64, result64;

  alu_iter #(.XLEN(32), .MUL_STEP(1)) dut (
    .clk(clk), .reset(reset), .kill(kill),
    .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2),
    .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .zero(zero), .less_than(less_than),
    .less_than_unsigned(less_than_unsigned)
  );

  alu_iter #(.XLEN(64), .MUL_STEP(4)) dut64 (
    .clk(clk), .reset(reset), .kill(kill),
    .in_valid(in_valid64), .in_ready(in_ready64), .op(op),
    .src1(src1_64), .src2(src2_64),
    .out_valid(out_valid64), .out_ready(out_ready),
    .result(result64), .zero(zero64), .less_than(lt64),
    .less_than_unsigned(ltu64)
  );

  typedef struct {
    logic [31:0] res;
    logic        z, lt, ltu;
    int          lat;
    int          acc;
  } exp_t;

  exp_t scb[$];
  int   errs = 0, checks = 0, cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  // Pop one expectation per transfer on the output side
  always @(negedge clk) begin
    exp_t e;
    if (!reset && out_valid && out_ready) begin
      if (scb.size() == 0) check("unexpected_out", 64'(out_valid), 64'd0);
      else begin
        e = scb.pop_front();
        check("result", 64'(result), 64'(e.res));
        check("zero", 64'(zero), 64'(e.z));
        check("less_than", 64'(less_than), 64'(e.lt));
        check("less_than_unsigned", 64'(less_than_unsigned), 64'(e.ltu));
        if (e.lat > 0) check("latency", 64'(cyc - e.acc + 1), 64'(e.lat));
      end
    end
  end

  function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    longint      sa, sbv;
    logic [63:0] p;
    logic [4:0]  sh;
    logic        ov;
    sa  = longint'($signed(a));
    sbv = longint'($signed(b));
    sh  = b[4:0];
    ov  = (a == 32'h80000000) && (b == 32'hFFFFFFFF);
    p   = '0;
    if (!o[4]) begin
      case (o[3:0])
        4'b0000: return a + b;
        4'b1000: return a - b;
        4'b0110: return a | b;
        4'b0111: return a & b;
        4'b0100: return a ^ b;
        4'b0010: return {31'b0, $signed(a) < $signed(b)};
        4'b0011: return {31'b0, a < b};
        4'b0001: return a << sh;
        4'b0101: return a >> sh;
        4'b1101: return 32'($signed(a) >>> sh);
        default: return 32'h0;
      endcase
    end
    case (o[2:0])
      3'd0: p = {32'b0, a} * {32'b0, b};
      3'd1: p = 64'(sa * sbv);
      3'd2: p = 64'(sa * longint'({32'b0, b}));
      3'd3: p = {32'b0, a} * {32'b0, b};
      3'd4: return (b == 0) ? 32'hFFFFFFFF : ov ? a : 32'($signed(a) / $signed(b));
      3'd5: return (b == 0) ? 32'hFFFFFFFF : a / b;
      3'd6: return (b == 0) ? a : ov ? 32'h0 : 32'($signed(a) % $signed(b));
      default: return (b == 0) ? a : a % b;
    endcase
    return (o[2:0] == 3'd0) ? p[31:0] : p[63:32];
  endfunction

  function automatic int lat_of(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b);
    if (!o[4]) return 1;
    if (!o[2]) return 33;
    if (b == 0 || (!o[0] && a == 32'h80000000 && b == 32'hFFFFFFFF)) return 1;
    return 33;
  endfunction

  task automatic issue(input logic [4:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] r, input int lat, input bit push);
    int   n = 0;
    exp_t e;
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
    if (!in_ready) check("accept_timeout", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    if (push) begin
      e.res = r; e.z = (a == b); e.lt = ($signed(a) < $signed(b)); e.ltu = (a < b);
      e.lat = lat; e.acc = cyc;
      scb.push_back(e);
    end
  endtask

  task automatic drain();
    int n = 0;
    while (scb.size() != 0 && n < 200) begin @(posedge clk); #1; n++; end
    if (scb.size() != 0) check("drain_timeout", 64'(scb.size()), 64'd0);
  endtask

  logic [4:0] codes [20] = '{5'h00, 5'h08, 5'h06, 5'h07, 5'h04, 5'h02, 5'h03, 5'h01, 5'h05, 5'h0D,
                             5'h09, 5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17, 5'h18};

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int          n, seen, acc;
    logic [4:0]  o;
    logic [31:0] a, b;

    reset = 1'b1; kill = 1'b0; in_valid = 1'b0; in_valid64 = 1'b0; out_ready = 1'b1;
    op = '0; src1 = '0; src2 = '0; src1_64 = '0; src2_64 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_result", 64'(result), 64'd0);
    check("rst_flags", 64'({zero, less_than, less_than_unsigned}), 64'd0);
    check("rst_out_valid64", 64'(out_valid64), 64'd0);
    reset = 1'b0;

    // Reset in the middle of a multiply discards it and clears the result
    issue(5'h00, 32'd1, 32'd1, 32'd2, 1, 1);
    drain();
    issue(5'h10, 32'd3, 32'd5, 32'd0, 0, 0);
    repeat (8) @(posedge clk);
    #1 reset = 1'b1;
    #1;
    check("midmul_rst_out_valid", 64'(out_valid), 64'd0);
    check("midmul_rst_result", 64'(result), 64'd0);
    @(posedge clk); #1 reset = 1'b0;
    issue(5'h00, 32'd5, 32'd7, 32'd12, 1, 1);
    drain();

    // Back-to-back base ops
    issue(5'h08, 32'd3, 32'd5, 32'hFFFFFFFE, 1, 1);
    issue(5'h0D, 32'h80000000, 32'd4, 32'hF8000000, 1, 1);
    issue(5'h03, 32'd1, 32'hFFFFFFFF, 32'd1, 1, 1);
    drain();

    // Multiply / divide and divide fast paths
    issue(5'h11, 32'h80000000, 32'h80000000, 32'h40000000, 33, 1);
    issue(5'h12, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 33, 1);
    issue(5'h10, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB, 33, 1);
    issue(5'h14, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 33, 1);
    issue(5'h16, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 33, 1);
    issue(5'h15, 32'd9, 32'd0, 32'hFFFFFFFF, 1, 1);
    issue(5'h16, 32'd9, 32'd0, 32'd9, 1, 1);
    issue(5'h14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1);
    issue(5'h16, 32'h80000000, 32'hFFFFFFFF, 32'd0, 1, 1);
    drain();

    // Backpressure holds the result and blocks new accepts
    out_ready = 1'b0;
    issue(5'h00, 32'd10, 32'd20, 32'd30, 0, 1);
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("bp_out_valid", 64'(out_valid), 64'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_result_hold", 64'(result), 64'd30);
      check("bp_in_ready", 64'(in_ready), 64'd0);
    end
    @(posedge clk); #1 out_ready = 1'b1;
    drain();

    // kill mid-divide: back to idle, nothing delivered, kill-cycle offer dropped
    issue(5'h14, 32'd100, 32'd7, 32'd0, 0, 0);
    repeat (18) @(posedge clk);
    #1 kill = 1'b1; op = 5'h00; src1 = 32'd1; src2 = 32'd1; in_valid = 1'b1;
    #1 check("kill_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1 kill = 1'b0; in_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("kill_no_out_valid", 64'(seen), 64'd0);
    check("kill_idle_ready", 64'(in_ready), 64'd1);

    // Random mix against the reference model
    for (int i = 0; i < 40; i++) begin
      o = codes[$urandom_range(0, 19)];
      a = ($urandom_range(0, 7) == 0) ? 32'h80000000 : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1:       b = 32'hFFFFFFFF;
        default: b = 32'($urandom);
      endcase
      issue(o, a, b, model(o, a, b), lat_of(o, a, b), 1);
    end
    drain();

    // 64-bit instance, four multiplier bits per cycle
    op = 5'h13; src1_64 = '1; src2_64 = '1; in_valid64 = 1'b1;
    #1 check("x64_in_ready", 64'(in_ready64), 64'd1);
    @(posedge clk); #1 in_valid64 = 1'b0;
    acc = cyc;
    n = 0;
    while (!out_valid64 && n < 100) begin @(negedge clk); n++; end
    check("x64_mulhu", result64, 64'hFFFFFFFFFFFFFFFE);
    check("x64_latency", 64'(cyc - acc + 1), 64'd17);
    @(posedge clk); #1;

    check("scoreboard_empty", 64'(scb.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
